// File: rtl/rle_decompressor.sv
// Run-length decoder: expands (count, value) records into consecutive RAM writes until a zero-count marker.
// First write two cycles after the count is accepted; stall_i holds emission, input is taken only while fetching.
module rle_decompressor #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              stall_i,
  output logic [DATA_W-1:0] data_out_o,
  output logic              write_en_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GET_COUNT = 3'd1;
  localparam logic [2:0] S_GET_VALUE = 3'd2;
  localparam logic [2:0] S_EMIT      = 3'd3;
  localparam logic [2:0] S_DONE      = 3'd4;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] remain_q, remain_d;
  logic [DATA_W-1:0] value_q, value_d;

  logic fetching;
  logic in_fire;
  logic wr_fire;

  assign fetching = (state_q == S_GET_COUNT) || (state_q == S_GET_VALUE);

  // A Start cycle never completes a handshake, so ready is masked by it.
  assign in_ready_o = fetching && !start_i;
  assign in_fire    = in_valid_i && in_ready_o;
  assign write_en_o = (state_q == S_EMIT) && !stall_i;
  assign wr_fire    = write_en_o;

  assign data_out_o = value_q;
  assign addr_o     = addr_q;
  assign busy_o     = fetching || (state_q == S_EMIT);
  assign done_o     = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    value_d  = value_q;

    if (start_i) begin
      addr_d   = base_addr_i;
      remain_d = '0;
      state_d  = S_GET_COUNT;
    end else begin
      case (state_q)
        S_GET_COUNT: begin
          if (in_fire) begin
            if (in_data_i != '0) begin
              remain_d = in_data_i;
              state_d  = S_GET_VALUE;
            end else begin
              state_d  = S_DONE;
            end
          end
        end
        S_GET_VALUE: begin
          if (in_fire) begin
            value_d = in_data_i;
            state_d = S_EMIT;
          end
        end
        S_EMIT: begin
          if (wr_fire) begin
            addr_d   = addr_q + ADDR_ONE;
            remain_d = remain_q - DATA_ONE;
            if (remain_q == DATA_ONE) begin
              state_d = S_GET_COUNT;
            end
          end
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      value_q  <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      value_q  <= value_d;
    end
  end

endmodule

// File: tb/tb_rle_decompressor.sv
// Bench for rle_decompressor: cycle-exact vector table, reset abort sequence, randomized streams vs a record-expansion model.
module tb_rle_decompressor;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        start_i;
  logic [15:0] base_addr_i;
  logic [15:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        stall_i;
  logic [15:0] data_out_o;
  logic        write_en_o;
  logic [15:0] addr_o;
  logic        busy_o;
  logic        done_o;

  rle_decompressor #(.DATA_W(16), .ADDR_W(16)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .start_i     (start_i),
    .base_addr_i (base_addr_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .stall_i     (stall_i),
    .data_out_o  (data_out_o),
    .write_en_o  (write_en_o),
    .addr_o      (addr_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        st;
    logic [15:0] base;
    logic        vld;
    logic [15:0] dat;
    logic        stl;
    logic        rdy;
    logic        we;
    logic [15:0] addr;
    logic [15:0] dout;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [15:0] words[$];
  logic [15:0] exp_a[$];
  logic [15:0] exp_d[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic row(input int st, input int base, input int vld, input int dat, input int stl,
                     input int rdy, input int we, input int addr, input int dout,
                     input int busy, input int done);
    vec_t v;
    v.st = st[0];  v.base = base[15:0]; v.vld = vld[0]; v.dat = dat[15:0]; v.stl = stl[0];
    v.rdy = rdy[0]; v.we = we[0]; v.addr = addr[15:0]; v.dout = dout[15:0];
    v.busy = busy[0]; v.done = done[0];
    tbl.push_back(v);
  endtask

  task automatic check_outs(input string tag, input logic rdy, input logic we, input logic [15:0] addr,
                            input logic [15:0] dout, input logic busy, input logic done);
    chk({tag, " in_ready"}, 32'(in_ready_o), 32'(rdy));
    chk({tag, " write_en"}, 32'(write_en_o), 32'(we));
    chk({tag, " addr"},     32'(addr_o),     32'(addr));
    chk({tag, " data_out"}, 32'(data_out_o), 32'(dout));
    chk({tag, " busy"},     32'(busy_o),     32'(busy));
    chk({tag, " done"},     32'(done_o),     32'(done));
  endtask

  // Expected writes come straight from the record list: Count copies of Value at base, base+1, ...
  task automatic build_expect(input logic [15:0] base, output logic [15:0] end_addr);
    logic [15:0] a;
    int          i;
    a = base;
    i = 0;
    exp_a.delete();
    exp_d.delete();
    while (i < words.size() && words[i] != 16'h0) begin
      for (int k = 0; k < int'(words[i]); k++) begin
        exp_a.push_back(a);
        exp_d.push_back(words[i+1]);
        a = a + 16'h1;
      end
      i += 2;
    end
    end_addr = a;
  endtask

  task automatic run_stream(input string tag, input logic [15:0] base, input int gap_pct,
                            input int stall_pct, input int limit, output int cycles);
    logic [15:0] end_addr;
    int          bad_wr;
    build_expect(base, end_addr);
    bad_wr = 0;
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = base; in_valid_i = 1'b0; stall_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0;
    cycles = 0;
    while (!done_o && cycles < limit) begin
      in_valid_i = (words.size() > 0) && ($urandom_range(99) >= gap_pct);
      in_data_i  = (words.size() > 0) ? words[0] : 16'h0;
      stall_i    = ($urandom_range(99) < stall_pct);
      #1;
      if (write_en_o) begin
        if (exp_a.size() == 0) bad_wr++;
        else begin
          if (addr_o !== exp_a[0] || data_out_o !== exp_d[0]) bad_wr++;
          void'(exp_a.pop_front());
          void'(exp_d.pop_front());
        end
      end
      if (in_valid_i && in_ready_o) void'(words.pop_front());
      @(negedge clk_i);
      cycles++;
    end
    in_valid_i = 1'b0;
    stall_i    = 1'b0;
    chk({tag, " done reached"}, 32'(done_o), 32'd1);
    chk({tag, " wrong writes"}, 32'(bad_wr), 32'd0);
    chk({tag, " missing writes"}, 32'(exp_a.size()), 32'd0);
    chk({tag, " words left"}, 32'(words.size()), 32'd0);
    chk({tag, " final addr"}, 32'(addr_o), 32'(end_addr));
  endtask

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    rst_n_i = 1'b0; start_i = 1'b0; base_addr_i = '0; in_data_i = '0;
    in_valid_i = 1'b0; stall_i = 1'b0;

    // Basic stream (3,ABCD),(1,0007),(0); words held during EMIT are not consumed
    row(0,'h0000,1,'h0009,0, 0,0,'h0000,'h0000,0,0);
    row(1,'h0100,0,'h0000,0, 0,0,'h0000,'h0000,0,0);
    row(0,'h0000,1,'h0003,0, 1,0,'h0100,'h0000,1,0);
    row(0,'h0000,1,'hABCD,0, 1,0,'h0100,'h0000,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0100,'hABCD,1,0);
    row(0,'h0000,1,'h0001,0, 0,1,'h0101,'hABCD,1,0);
    row(0,'h0000,1,'h0001,0, 0,1,'h0102,'hABCD,1,0);
    row(0,'h0000,1,'h0001,0, 1,0,'h0103,'hABCD,1,0);
    row(0,'h0000,1,'h0007,0, 1,0,'h0103,'hABCD,1,0);
    row(0,'h0000,1,'h0000,0, 0,1,'h0103,'h0007,1,0);
    row(0,'h0000,1,'h0000,0, 1,0,'h0104,'h0007,1,0);
    row(0,'h0000,1,'h1234,0, 0,0,'h0104,'h0007,0,1);
    // Stall on 2nd and 3rd emit cycles of (4,1111)
    row(1,'h0200,0,'h0000,0, 0,0,'h0104,'h0007,0,1);
    row(0,'h0000,1,'h0004,0, 1,0,'h0200,'h0007,1,0);
    row(0,'h0000,1,'h1111,0, 1,0,'h0200,'h0007,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0200,'h1111,1,0);
    row(0,'h0000,0,'h0000,1, 0,0,'h0201,'h1111,1,0);
    row(0,'h0000,0,'h0000,1, 0,0,'h0201,'h1111,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0201,'h1111,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0202,'h1111,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0203,'h1111,1,0);
    row(0,'h0000,0,'h0000,1, 1,0,'h0204,'h1111,1,0);
    row(0,'h0000,1,'h0000,0, 1,0,'h0204,'h1111,1,0);
    row(0,'h0000,0,'h0000,0, 0,0,'h0204,'h1111,0,1);
    // Restart mid-EMIT of (10,2222) with base 0x0040
    row(1,'h0300,0,'h0000,0, 0,0,'h0204,'h1111,0,1);
    row(0,'h0000,1,'h000A,0, 1,0,'h0300,'h1111,1,0);
    row(0,'h0000,0,'h0000,0, 1,0,'h0300,'h1111,1,0);
    row(0,'h0000,1,'h2222,0, 1,0,'h0300,'h1111,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0300,'h2222,1,0);
    row(1,'h0040,0,'h0000,0, 0,1,'h0301,'h2222,1,0);
    row(0,'h0000,1,'h0002,0, 1,0,'h0040,'h2222,1,0);
    row(0,'h0000,1,'h3333,0, 1,0,'h0040,'h2222,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0040,'h3333,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0041,'h3333,1,0);
    row(0,'h0000,1,'h0000,0, 1,0,'h0042,'h3333,1,0);
    row(0,'h0000,0,'h0000,0, 0,0,'h0042,'h3333,0,1);
    // Address wrap from 0xFFFE
    row(1,'hFFFE,0,'h0000,0, 0,0,'h0042,'h3333,0,1);
    row(0,'h0000,1,'h0004,0, 1,0,'hFFFE,'h3333,1,0);
    row(0,'h0000,1,'h5A5A,0, 1,0,'hFFFE,'h3333,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'hFFFE,'h5A5A,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'hFFFF,'h5A5A,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0000,'h5A5A,1,0);
    row(0,'h0000,0,'h0000,0, 0,1,'h0001,'h5A5A,1,0);
    row(0,'h0000,1,'h0000,0, 1,0,'h0002,'h5A5A,1,0);
    row(0,'h0000,0,'h0000,0, 0,0,'h0002,'h5A5A,0,1);
    // Start while fetching masks the handshake; the held count is taken afterwards
    row(1,'h0500,0,'h0000,0, 0,0,'h0002,'h5A5A,0,1);
    row(1,'h0600,1,'h0007,0, 0,0,'h0500,'h5A5A,1,0);
    row(0,'h0000,1,'h0001,0, 1,0,'h0600,'h5A5A,1,0);
    row(0,'h0000,1,'h0BAD,0, 1,0,'h0600,'h5A5A,1,0);
    row(0,'h0000,1,'h0000,0, 0,1,'h0600,'h0BAD,1,0);
    row(0,'h0000,1,'h0000,0, 1,0,'h0601,'h0BAD,1,0);
    row(0,'h0000,0,'h0000,0, 0,0,'h0601,'h0BAD,0,1);

    repeat (2) @(negedge clk_i);
    #1;
    check_outs("reset", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk_i);
      start_i = tbl[i].st; base_addr_i = tbl[i].base; in_valid_i = tbl[i].vld;
      in_data_i = tbl[i].dat; stall_i = tbl[i].stl;
      #1;
      check_outs($sformatf("row %0d", i), tbl[i].rdy, tbl[i].we, tbl[i].addr,
                 tbl[i].dout, tbl[i].busy, tbl[i].done);
    end

    // Asynchronous reset in the middle of an emission
    @(negedge clk_i);
    start_i = 1'b1; base_addr_i = 16'h0700; in_valid_i = 1'b0; stall_i = 1'b0;
    @(negedge clk_i);
    start_i = 1'b0; in_valid_i = 1'b1; in_data_i = 16'h0005;
    @(negedge clk_i);
    in_data_i = 16'h7777;
    @(negedge clk_i);
    in_valid_i = 1'b0;
    #1;
    chk("pre-reset write_en", 32'(write_en_o), 32'd1);
    @(negedge clk_i);
    rst_n_i = 1'b0;
    #1;
    check_outs("mid-emit reset", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    rst_n_i = 1'b1; in_valid_i = 1'b1; in_data_i = 16'h0003;
    #1;
    check_outs("idle after reset", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    @(negedge clk_i);
    #1;
    check_outs("idle holds", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    in_valid_i = 1'b0;

    // Randomized streams with gaps and stalls
    for (int s = 0; s < 15; s++) begin
      logic [15:0] base;
      int          nrec;
      base = (s == 3) ? 16'hFFFD : 16'($urandom);
      nrec = $urandom_range(1, 5);
      words.delete();
      for (int r = 0; r < nrec; r++) begin
        words.push_back(16'($urandom_range(1, 7)));
        words.push_back(16'($urandom));
      end
      words.push_back(16'h0000);
      run_stream($sformatf("rand %0d", s), base, 30, 30, 2000, cyc);
    end

    // Maximum count with no gaps: L writes take L+3 cycles including the marker
    words.delete();
    words.push_back(16'hFFFF);
    words.push_back(16'hC3C3);
    words.push_back(16'h0000);
    run_stream("max count", 16'h1234, 0, 0, 70000, cyc);
    chk("max count cycles", 32'(cyc), 32'd65538);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rle_decompressor.md
# rle_decompressor

Run-length decoder sitting directly upstream of the RAM input multiplexer. It drives the mux's decompressed-data input and the matching RAM write strobe and address. It consumes a 16-bit compressed word stream of (Count, Value) records over a valid/ready handshake. It expands each record into Count consecutive RAM writes of Value at incrementing addresses, until a zero-count end marker arrives.

## Interface
- DATA_W, 16, width of compressed words and decompressed data
- ADDR_W, 16, width of RAM write address
- Clk  input  1  clock; all state changes on rising edge
- RstN  input  1  asynchronous, active-low reset
- Start  input  1  single-cycle pulse; loads base address, begins a new stream (aborts any stream in progress)
- BaseAddr  input  ADDR_W  first RAM address; sampled on Start
- InData  input  DATA_W  compressed stream word
- InValid  input  1  InData valid
- InReady  output  1  block accepts InData this cycle
- Stall  input  1  RAM side not accepting writes; holds emission
- DataOut  output  DATA_W  decompressed word; feeds mux decompressed-data input
- WriteEn  output  1  DataOut/Addr valid as a RAM write this cycle
- Addr  output  ADDR_W  RAM write address
- Busy  output  1  stream in progress (state not IDLE/DONE)
- Done  output  1  level; end marker consumed; held until next Start

## Operation
- Stream format: record = Count word, then Value word. Count in 1..2^DATA_W-1 means emit Value Count times. Count = 0 is the end marker; no Value word follows.
- States:
  - IDLE: entered on reset. Waits for Start.
  - GET_COUNT: InReady=1. On InValid, with Count≠0, latch Remaining=Count and go to GET_VALUE. With Count=0, go to DONE.
  - GET_VALUE: InReady=1. On InValid, latch ValueReg and go to EMIT.
  - EMIT: InReady=0. WriteEn = !Stall, DataOut=ValueReg, Addr=AddrReg. On each cycle with !Stall: AddrReg+=1, Remaining-=1. When a write occurs with Remaining==1, go to GET_COUNT.
  - DONE: Done=1, InReady=0. Waits for Start.
- Start in any state: AddrReg←BaseAddr, Remaining←0, Done←0, next state GET_COUNT. The current cycle's handshake is ignored (InReady forced 0 in the Start cycle).
- Addr arithmetic modulo 2^ADDR_W: 2^ADDR_W-1 wraps to 0 with no flag.
- Remaining is DATA_W wide; Count=2^DATA_W-1 must emit exactly that many writes.
- DataOut = ValueReg in all states. Consumers qualify it with WriteEn only.
- InValid without InReady is ignored. The upstream holds data; no word is dropped or duplicated.

## Timing
- Reset (RstN=0, async): state IDLE, InReady=0, WriteEn=0, DataOut=0, Addr=0, Busy=0, Done=0, internal registers 0.
- WriteEn, InReady, Busy and Done are decoded from registered state; no combinational path from InValid to InReady.
- Stall→WriteEn is combinational (same cycle); Stall does not affect the other outputs.
- Latency:
  - Start at cycle S → InReady=1 at S+1.
  - Count accepted at N, Value accepted at earliest N+1 → first WriteEn at N+2.
  - Record of length L without stalls occupies 2+L cycles.
- Last write of a record at cycle M → InReady=1 at M+1. No bubble beyond the handshake.
- End marker accepted at N → Done=1, Busy=0 from N+1.
- Reset mid-EMIT aborts immediately. No further WriteEn after RstN asserts.

## Test plan
- Reset: assert RstN=0 mid-EMIT → WriteEn, InReady, Busy, Done, Addr, DataOut all 0 in the same cycle; state IDLE after release.
- Basic stream: Start with BaseAddr=0x0100, feed (3,0xABCD),(1,0x0007),(0) back-to-back:
  - WriteEn on 4 cycles at Addr 0x0100–0x0102 with DataOut 0xABCD, then 0x0103 with 0x0007.
  - Done=1 the cycle after the marker.
- Stall: record (4,0x1111) with Stall high on the 2nd and 3rd emit cycles → exactly 4 writes at consecutive addresses; Addr holds during the stall; WriteEn=0 while stalled.
- Input gaps: InValid toggled low between Count and Value and between records → identical write sequence to the no-gap case; no word consumed while InValid=0.
- Address wrap: BaseAddr=0xFFFE, record (4,0x5A5A) → Addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
- Restart: Start pulsed mid-EMIT of (10,0x2222) with BaseAddr=0x0040 → emission stops the next cycle; InReady=1; the next record writes from 0x0040; Done stays 0.
